// File: rtl/pixel_transform_engine.sv
// Pixel transform engine: walks every destination pixel in raster order,
// asks the coordinate mapper where it comes from, fetches that source pixel
// (or substitutes the background colour when out of range) and writes it to
// the transformed frame buffer. Pulses done once the whole frame is written.
module pixel_transform_engine #(
  parameter int WIDTH        = 640,
  parameter int HEIGHT       = 480,
  parameter int X_W          = 10,
  parameter int Y_W          = 9,
  parameter int ADDR_W       = 19,
  parameter int PIX_W        = 12,
  parameter int READ_LATENCY = 2,
  parameter logic [PIX_W-1:0] BG_COLOR = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              coord_req,
  output logic [X_W-1:0]    coord_x,
  output logic [Y_W-1:0]    coord_y,
  input  logic              coord_valid,
  input  logic [X_W-1:0]    src_x,
  input  logic [Y_W-1:0]    src_y,
  input  logic              src_in_range,
  output logic [ADDR_W-1:0] src_addr,
  output logic              src_rd_en,
  input  logic [PIX_W-1:0]  src_data,
  output logic [ADDR_W-1:0] dst_addr,
  output logic [PIX_W-1:0]  dst_data,
  output logic              dst_we
);

  // Wide enough to count 0..READ_LATENCY inclusive.
  localparam int CNT_W = $clog2(READ_LATENCY + 1) + 1;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT_COORD,
    READ,
    WAIT_DATA,
    WRITE,
    DONE
  } state_t;

  state_t             state;
  logic [X_W-1:0]     src_x_q;
  logic [Y_W-1:0]     src_y_q;
  logic [ADDR_W-1:0]  dst_ptr;
  logic [CNT_W-1:0]   lat_cnt;

  // Linear frame address y*WIDTH + x, unsigned, truncated to ADDR_W.
  function automatic logic [ADDR_W-1:0] addr_of(input logic [Y_W-1:0] yy,
                                                input logic [X_W-1:0] xx);
    logic [ADDR_W-1:0] row;
    logic [ADDR_W-1:0] col;
    logic [ADDR_W-1:0] w;
    row = ADDR_W'(yy);
    col = ADDR_W'(xx);
    w   = ADDR_W'(WIDTH);
    return row * w + col;
  endfunction

  // Raster-scan controller; all handshake and memory strobes are registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      coord_req <= 1'b0;
      coord_x   <= '0;
      coord_y   <= '0;
      src_addr  <= '0;
      src_rd_en <= 1'b0;
      dst_addr  <= '0;
      dst_data  <= '0;
      dst_we    <= 1'b0;
      src_x_q   <= '0;
      src_y_q   <= '0;
      dst_ptr   <= '0;
      lat_cnt   <= '0;
    end else begin
      // Strobes are single-cycle unless re-asserted below.
      src_rd_en <= 1'b0;
      dst_we    <= 1'b0;
      done      <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            coord_x <= '0;
            coord_y <= '0;
            dst_ptr <= '0;
            busy    <= 1'b1;
            state   <= REQ;
          end
        end
        REQ: begin
          coord_req <= 1'b1;
          state     <= WAIT_COORD;
        end
        WAIT_COORD: begin
          // coord_x/coord_y stay frozen here so the mapper sees a stable request.
          if (coord_valid) begin
            coord_req <= 1'b0;
            src_x_q   <= src_x;
            src_y_q   <= src_y;
            if (src_in_range) begin
              state <= READ;
            end else begin
              dst_we   <= 1'b1;
              dst_addr <= dst_ptr;
              dst_data <= BG_COLOR;
              state    <= WRITE;
            end
          end
        end
        READ: begin
          src_addr  <= addr_of(src_y_q, src_x_q);
          src_rd_en <= 1'b1;
          lat_cnt   <= '0;
          state     <= WAIT_DATA;
        end
        WAIT_DATA: begin
          // lat_cnt is 0 in the cycle the read strobe is visible, so the data
          // is valid in the cycle where it reaches READ_LATENCY.
          if (lat_cnt == CNT_W'(READ_LATENCY)) begin
            dst_we   <= 1'b1;
            dst_addr <= dst_ptr;
            dst_data <= src_data;
            state    <= WRITE;
          end else begin
            lat_cnt <= lat_cnt + 1'b1;
          end
        end
        WRITE: begin
          dst_ptr <= dst_ptr + 1'b1;
          if (coord_x == X_W'(WIDTH - 1) && coord_y == Y_W'(HEIGHT - 1)) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            if (coord_x == X_W'(WIDTH - 1)) begin
              coord_x <= '0;
              coord_y <= coord_y + 1'b1;
            end else begin
              coord_x <= coord_x + 1'b1;
            end
            state <= REQ;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pixel_transform_engine.sv
// Directed bench for pixel_transform_engine on a 4x3 frame with a behavioural
// coordinate mapper and a 2-cycle-latency source memory returning its address.
module tb_pixel_transform_engine;

  localparam int WIDTH  = 4;
  localparam int HEIGHT = 3;
  localparam int X_W    = 10;
  localparam int Y_W    = 9;
  localparam int ADDR_W = 19;
  localparam int PIX_W  = 12;
  localparam int RL     = 2;
  localparam int NPIX   = WIDTH * HEIGHT;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic              busy, done, coord_req, src_rd_en, dst_we;
  logic [X_W-1:0]    coord_x;
  logic [Y_W-1:0]    coord_y;
  logic              coord_valid = 1'b0;
  logic [X_W-1:0]    src_x = '0;
  logic [Y_W-1:0]    src_y = '0;
  logic              src_in_range = 1'b0;
  logic [ADDR_W-1:0] src_addr, dst_addr;
  logic [PIX_W-1:0]  src_data = '0;
  logic [PIX_W-1:0]  dst_data;

  pixel_transform_engine #(
    .WIDTH(WIDTH), .HEIGHT(HEIGHT), .X_W(X_W), .Y_W(Y_W), .ADDR_W(ADDR_W),
    .PIX_W(PIX_W), .READ_LATENCY(RL), .BG_COLOR(12'h000)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .coord_req(coord_req), .coord_x(coord_x), .coord_y(coord_y),
    .coord_valid(coord_valid), .src_x(src_x), .src_y(src_y),
    .src_in_range(src_in_range), .src_addr(src_addr), .src_rd_en(src_rd_en),
    .src_data(src_data), .dst_addr(dst_addr), .dst_data(dst_data), .dst_we(dst_we)
  );

  always #5 clk = ~clk;

  // Mapper configuration (written only by the main sequence).
  int map_delay = 1;
  bit oor_en    = 1'b0;
  bit const_en  = 1'b0;
  bit clear_req = 1'b0;

  // Observation log (written only by the model process).
  int wr_addr [0:63];
  int wr_data [0:63];
  int rd_addr [0:63];
  int wr_cnt = 0, rd_cnt = 0, done_cnt = 0, done_wr_snap = 0, done_busy_err = 0;
  int coord_chg_err = 0, req_run = 0, max_req_run = 0;
  int wcnt = 0;
  logic              prev_req = 1'b0;
  logic [X_W-1:0]    prev_x = '0;
  logic [Y_W-1:0]    prev_y = '0;
  logic [PIX_W-1:0]  d1 = 12'hFFF, d2 = 12'hFFF;

  int tests = 0;
  int fails = 0;

  // Source memory, mapper and monitor, all evaluated mid-cycle.
  initial begin
    forever begin
      @(negedge clk);
      src_data = d2;
      d2 = d1;
      d1 = src_rd_en ? src_addr[PIX_W-1:0] : 12'hFFF;
      if (!coord_req) begin
        coord_valid = 1'b0;
        wcnt = 0;
      end else if (!coord_valid) begin
        if (wcnt >= map_delay) begin
          coord_valid = 1'b1;
          if (const_en) begin
            src_x = X_W'(3);
            src_y = Y_W'(2);
          end else begin
            src_x = coord_x;
            src_y = coord_y;
          end
          src_in_range = !(oor_en && coord_x == 1 && coord_y == 1);
        end else begin
          wcnt++;
        end
      end
      if (clear_req) begin
        wr_cnt = 0; rd_cnt = 0; done_cnt = 0; done_wr_snap = 0; done_busy_err = 0;
        coord_chg_err = 0; req_run = 0; max_req_run = 0;
      end
      if (dst_we) begin
        if (wr_cnt < 64) begin
          wr_addr[wr_cnt] = int'(dst_addr);
          wr_data[wr_cnt] = int'(dst_data);
        end
        wr_cnt++;
      end
      if (src_rd_en) begin
        if (rd_cnt < 64) rd_addr[rd_cnt] = int'(src_addr);
        rd_cnt++;
      end
      if (done) begin
        done_cnt++;
        done_wr_snap = wr_cnt;
        if (busy) done_busy_err++;
      end
      if (coord_req && prev_req && (coord_x != prev_x || coord_y != prev_y)) coord_chg_err++;
      if (coord_req) req_run++;
      else if (prev_req) begin
        if (req_run > max_req_run) max_req_run = req_run;
        req_run = 0;
      end
      prev_req = coord_req;
      prev_x = coord_x;
      prev_y = coord_y;
    end
  end

  task automatic clear_log();
    clear_req = 1'b1;
    @(negedge clk);
    #1;
    clear_req = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
  endtask

  task automatic wait_done(input int n);
    int k;
    k = 0;
    while (done_cnt < n && k < 1500) begin
      @(negedge clk);
      #1;
      k++;
    end
    tests++;
    if (done_cnt < n) begin
      fails++;
      $display("FAIL done_timeout: got %0d done pulses, expected %0d", done_cnt, n);
    end
  endtask

  task automatic wait_writes(input int n);
    int k;
    k = 0;
    while (wr_cnt < n && k < 1500) begin
      @(negedge clk);
      #1;
      k++;
    end
    tests++;
    if (wr_cnt < n) begin
      fails++;
      $display("FAIL write_timeout: got %0d writes, expected %0d", wr_cnt, n);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    start = 1'b1;
    @(negedge clk);
    #1;
    tests++; if (busy !== 1'b0)      begin fails++; $display("FAIL rst_busy: got %b expected 0", busy); end
    tests++; if (done !== 1'b0)      begin fails++; $display("FAIL rst_done: got %b expected 0", done); end
    tests++; if (coord_req !== 1'b0) begin fails++; $display("FAIL rst_coord_req: got %b expected 0", coord_req); end
    tests++; if (src_rd_en !== 1'b0) begin fails++; $display("FAIL rst_rd_en: got %b expected 0", src_rd_en); end
    tests++; if (dst_we !== 1'b0)    begin fails++; $display("FAIL rst_we: got %b expected 0", dst_we); end
    tests++; if (coord_x !== '0 || coord_y !== '0) begin fails++; $display("FAIL rst_coord: got %0d,%0d expected 0,0", coord_x, coord_y); end
    tests++; if (src_addr !== '0 || dst_addr !== '0) begin fails++; $display("FAIL rst_addr: got %0d,%0d expected 0,0", src_addr, dst_addr); end
    tests++; if (dst_data !== '0)    begin fails++; $display("FAIL rst_data: got %0d expected 0", dst_data); end
    reset = 1'b0;
    start = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    tests++; if (busy !== 1'b0 || coord_req !== 1'b0) begin fails++; $display("FAIL rst_start_coincident: got busy=%b req=%b expected 0,0", busy, coord_req); end
  endtask

  task automatic test_identity();
    map_delay = 1; oor_en = 1'b0; const_en = 1'b0;
    clear_log();
    pulse_start();
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL id_busy_rise: got %b expected 1", busy); end
    wait_done(1);
    repeat (5) @(negedge clk);
    #1;
    tests++; if (wr_cnt !== NPIX) begin fails++; $display("FAIL id_writes: got %0d expected %0d", wr_cnt, NPIX); end
    tests++; if (rd_cnt !== NPIX) begin fails++; $display("FAIL id_reads: got %0d expected %0d", rd_cnt, NPIX); end
    tests++; if (done_cnt !== 1)  begin fails++; $display("FAIL id_done_cnt: got %0d expected 1", done_cnt); end
    tests++; if (done_busy_err !== 0) begin fails++; $display("FAIL id_busy_at_done: got %0d expected 0", done_busy_err); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL id_busy_end: got %b expected 0", busy); end
    for (int i = 0; i < NPIX; i++) begin
      tests++; if (wr_addr[i] !== i) begin fails++; $display("FAIL id_addr[%0d]: got %0d expected %0d", i, wr_addr[i], i); end
      tests++; if (wr_data[i] !== i) begin fails++; $display("FAIL id_data[%0d]: got %0d expected %0d", i, wr_data[i], i); end
    end
  endtask

  task automatic test_out_of_range();
    int bad_rd;
    map_delay = 1; oor_en = 1'b1; const_en = 1'b0;
    clear_log();
    pulse_start();
    wait_done(1);
    oor_en = 1'b0;
    tests++; if (wr_cnt !== NPIX) begin fails++; $display("FAIL oor_writes: got %0d expected %0d", wr_cnt, NPIX); end
    tests++; if (rd_cnt !== NPIX - 1) begin fails++; $display("FAIL oor_reads: got %0d expected %0d", rd_cnt, NPIX - 1); end
    bad_rd = 0;
    for (int i = 0; i < rd_cnt && i < 64; i++) if (rd_addr[i] == 5) bad_rd++;
    tests++; if (bad_rd !== 0) begin fails++; $display("FAIL oor_read_of_5: got %0d expected 0", bad_rd); end
    for (int i = 0; i < NPIX; i++) begin
      tests++; if (wr_addr[i] !== i) begin fails++; $display("FAIL oor_addr[%0d]: got %0d expected %0d", i, wr_addr[i], i); end
      tests++; if (wr_data[i] !== ((i == 5) ? 0 : i)) begin fails++; $display("FAIL oor_data[%0d]: got %0d expected %0d", i, wr_data[i], (i == 5) ? 0 : i); end
    end
  endtask

  task automatic test_slow_mapper();
    map_delay = 5; oor_en = 1'b0; const_en = 1'b0;
    clear_log();
    pulse_start();
    wait_done(1);
    map_delay = 1;
    tests++; if (coord_chg_err !== 0) begin fails++; $display("FAIL slow_coord_stable: got %0d changes expected 0", coord_chg_err); end
    tests++; if (max_req_run !== 6) begin fails++; $display("FAIL slow_req_hold: got %0d cycles expected 6", max_req_run); end
    tests++; if (wr_cnt !== NPIX) begin fails++; $display("FAIL slow_writes: got %0d expected %0d", wr_cnt, NPIX); end
    for (int i = 0; i < NPIX; i++) begin
      tests++; if (wr_data[i] !== i) begin fails++; $display("FAIL slow_data[%0d]: got %0d expected %0d", i, wr_data[i], i); end
    end
  endtask

  task automatic test_restart_ignored();
    map_delay = 1; oor_en = 1'b0; const_en = 1'b0;
    clear_log();
    pulse_start();
    wait_writes(6);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(1);
    repeat (40) @(negedge clk);
    #1;
    tests++; if (wr_cnt !== NPIX) begin fails++; $display("FAIL restart_writes: got %0d expected %0d", wr_cnt, NPIX); end
    tests++; if (done_cnt !== 1)  begin fails++; $display("FAIL restart_done_cnt: got %0d expected 1", done_cnt); end
    tests++; if (busy !== 1'b0)   begin fails++; $display("FAIL restart_busy: got %b expected 0", busy); end
    for (int i = 0; i < NPIX; i++) begin
      tests++; if (wr_addr[i] !== i) begin fails++; $display("FAIL restart_addr[%0d]: got %0d expected %0d", i, wr_addr[i], i); end
    end
  endtask

  task automatic test_reset_mid();
    int rd_snap;
    map_delay = 1; oor_en = 1'b0; const_en = 1'b0;
    clear_log();
    pulse_start();
    wait_writes(7);
    reset = 1'b1;
    @(negedge clk);
    #1;
    reset = 1'b0;
    rd_snap = rd_cnt;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL midrst_busy: got %b expected 0", busy); end
    tests++; if (dst_we !== 1'b0 || coord_req !== 1'b0) begin fails++; $display("FAIL midrst_strobes: got we=%b req=%b expected 0,0", dst_we, coord_req); end
    repeat (30) @(negedge clk);
    #1;
    tests++; if (wr_cnt !== 7)      begin fails++; $display("FAIL midrst_writes: got %0d expected 7", wr_cnt); end
    tests++; if (done_cnt !== 0)    begin fails++; $display("FAIL midrst_done: got %0d expected 0", done_cnt); end
    tests++; if (rd_cnt !== rd_snap) begin fails++; $display("FAIL midrst_reads: got %0d expected %0d", rd_cnt, rd_snap); end
    clear_log();
    pulse_start();
    wait_done(1);
    tests++; if (wr_cnt !== NPIX) begin fails++; $display("FAIL midrst_new_writes: got %0d expected %0d", wr_cnt, NPIX); end
    for (int i = 0; i < NPIX; i++) begin
      tests++; if (wr_addr[i] !== i || wr_data[i] !== i) begin fails++; $display("FAIL midrst_new[%0d]: got %0d/%0d expected %0d/%0d", i, wr_addr[i], wr_data[i], i, i); end
    end
  endtask

  task automatic test_const_map();
    int bad;
    map_delay = 1; oor_en = 1'b0; const_en = 1'b1;
    clear_log();
    pulse_start();
    wait_done(1);
    const_en = 1'b0;
    tests++; if (rd_cnt !== NPIX) begin fails++; $display("FAIL const_reads: got %0d expected %0d", rd_cnt, NPIX); end
    bad = 0;
    for (int i = 0; i < NPIX; i++) if (rd_addr[i] != 11) bad++;
    tests++; if (bad !== 0) begin fails++; $display("FAIL const_src_addr: got %0d wrong reads expected 0", bad); end
    for (int i = 0; i < NPIX; i++) begin
      tests++; if (wr_addr[i] !== i || wr_data[i] !== 11) begin fails++; $display("FAIL const_wr[%0d]: got %0d/%0d expected %0d/11", i, wr_addr[i], wr_data[i], i); end
    end
    tests++; if (done_wr_snap !== NPIX || wr_addr[NPIX-1] !== 11) begin fails++; $display("FAIL const_done_after_last: got %0d writes, last addr %0d expected %0d,11", done_wr_snap, wr_addr[NPIX-1], NPIX); end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    test_reset();
    test_identity();
    test_out_of_range();
    test_slow_mapper();
    test_restart_ignored();
    test_reset_mid();
    test_const_map();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
